// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg : shared widths, FSM state type and address field helpers
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package cache_pkg;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int INDEX_W  = 4;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;
  localparam int WORDS    = 1 << OFFSET_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_REFILL = 2'd2,
    ST_WRITE  = 2'd3
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_ctrl_if.sv
// -----------------------------------------------------------------------------
// cache_cpu_if / cache_mem_if : core-side and memory-side buses of cache_ctrl
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface cache_cpu_if import cache_pkg::*; ();
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              stall;

  modport master (output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, input cpu_rdata, stall);
  modport slave  (input cpu_rd, cpu_wr, cpu_addr, cpu_wdata, output cpu_rdata, stall);
endinterface

interface cache_mem_if import cache_pkg::*; ();
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (output mem_rd, mem_wr, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_rd, mem_wr, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

`default_nettype wire

// File: rtl/cache_line_store.sv
// -----------------------------------------------------------------------------
// cache_line_store : tag/valid/data arrays, one read port, word and tag writes
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module cache_line_store import cache_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_word,
  input  logic                word_we,
  input  logic [INDEX_W-1:0]  word_index,
  input  logic [OFFSET_W-1:0] word_offset,
  input  logic [DATA_W-1:0]   word_data,
  input  logic                tv_we,
  input  logic [INDEX_W-1:0]  tv_index,
  input  logic [TAG_W-1:0]    tv_tag,
  input  logic                tv_valid
);

  logic [LINES-1:0]                         valid_q, valid_d;
  logic [LINES-1:0][TAG_W-1:0]              tag_q, tag_d;
  logic [LINES-1:0][WORDS-1:0][DATA_W-1:0]  data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (word_we) begin
      data_d[word_index][word_offset] = word_data;
    end
    if (tv_we) begin
      valid_d[tv_index] = tv_valid;
      tag_d[tv_index]   = tv_tag;
    end
  end

  // Only the valid bits need reset; tag and data are don't-care while invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];
  assign rd_word  = data_q[rd_index][rd_offset];

endmodule

`default_nettype wire

// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl : direct-mapped write-through no-write-allocate cache controller
// Rev 1.0   Optional hit/miss statistics: define CACHE_STATS_EN
// -----------------------------------------------------------------------------
`default_nettype none

module cache_ctrl import cache_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  cache_cpu_if.slave  cpu,
  cache_mem_if.master mem,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;

  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_word;
  logic                hit;
  logic                ack;
  logic [DATA_W-1:0]   rdata;
  logic                mem_rd;
  logic                mem_wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                word_we;
  logic [OFFSET_W-1:0] word_offset;
  logic [DATA_W-1:0]   word_data;
  logic                tv_we;
  logic                tv_valid;

  cache_line_store u_store (
    .clk         (clk),
    .rst         (rst),
    .rd_index    (addr_index(addr_q)),
    .rd_offset   (addr_offset(addr_q)),
    .rd_tag      (rd_tag),
    .rd_valid    (rd_valid),
    .rd_word     (rd_word),
    .word_we     (word_we),
    .word_index  (addr_index(addr_q)),
    .word_offset (word_offset),
    .word_data   (word_data),
    .tv_we       (tv_we),
    .tv_index    (addr_index(addr_q)),
    .tv_tag      (addr_tag(addr_q)),
    .tv_valid    (tv_valid)
  );

  assign hit = rd_valid && (rd_tag == addr_tag(addr_q));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    ack         = 1'b0;
    rdata       = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    word_we     = 1'b0;
    word_offset = addr_offset(addr_q);
    word_data   = wdata_q;
    tv_we       = 1'b0;
    tv_valid    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu.cpu_wr) begin
          addr_d  = cpu.cpu_addr;
          wdata_d = cpu.cpu_wdata;
          state_d = ST_WRITE;
        end else if (cpu.cpu_rd) begin
          addr_d  = cpu.cpu_addr;
          state_d = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (hit) begin
          ack     = 1'b1;
          rdata   = rd_word;
          state_d = ST_IDLE;
        end else begin
          tv_we   = 1'b1;
          cnt_d   = '0;
          state_d = ST_REFILL;
        end
      end

      ST_REFILL: begin
        mem_rd   = 1'b1;
        mem_addr = {addr_q[ADDR_W-1:OFFSET_W], cnt_q};
        if (mem.mem_ready) begin
          word_we     = 1'b1;
          word_offset = cnt_q;
          word_data   = mem.mem_rdata;
          cnt_d       = cnt_q + 1'b1;
          // Last beat: the line becomes valid and LOOKUP re-runs as a hit.
          if (cnt_q == OFFSET_W'(WORDS - 1)) begin
            tv_we    = 1'b1;
            tv_valid = 1'b1;
            state_d  = ST_LOOKUP;
          end
        end
      end

      ST_WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem.mem_ready) begin
          ack     = 1'b1;
          word_we = hit;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu.cpu_rdata = rdata;
  assign cpu.stall     = (cpu.cpu_rd | cpu.cpu_wr) && !ack;
  assign mem.mem_rd    = mem_rd;
  assign mem.mem_wr    = mem_wr;
  assign mem.mem_addr  = mem_addr;
  assign mem.mem_wdata = mem_wdata;

`ifdef CACHE_STATS_EN
  logic        recheck_q, recheck_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // The LOOKUP that follows a refill is a guaranteed hit and is not counted.
  always_comb begin
    recheck_d  = recheck_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_REFILL && mem.mem_ready && cnt_q == OFFSET_W'(WORDS - 1)) begin
      recheck_d = 1'b1;
    end
    if (state_q == ST_LOOKUP) begin
      recheck_d = 1'b0;
      if (hit && !recheck_q && hit_cnt_q != 16'hFFFF) begin
        hit_cnt_d = hit_cnt_q + 16'd1;
      end
      if (!hit && miss_cnt_q != 16'hFFFF) begin
        miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      recheck_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      recheck_q  <= recheck_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl : randomized self-checking bench with a memory responder and a
// line-level reference model of the cache.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_cache_ctrl;
  import cache_pkg::*;

`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  always #5 clk = ~clk;

  cache_cpu_if cpu ();
  cache_mem_if mem ();

  cache_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .cpu      (cpu),
    .mem      (mem),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Main memory: word a holds 0xA000_0000 + a until stored to.
  logic [DATA_W-1:0] mem_arr [1<<ADDR_W];
  int                mem_lat = 1;
  logic [ADDR_W-1:0] rd_addrs [$];
  logic [ADDR_W-1:0] wr_addrs [$];
  logic [DATA_W-1:0] wr_datas [$];

  // Reference model: what the core should observe.
  logic [DATA_W-1:0] exp_mem [1<<ADDR_W];
  bit                ref_valid [LINES];
  logic [TAG_W-1:0]  ref_tag [LINES];
  int                ref_hits;
  int                ref_misses;

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      mem_arr[a] = 32'hA000_0000 + a;
      exp_mem[a] = 32'hA000_0000 + a;
    end
  end

  // Memory responder: ready arrives mem_lat cycles after the strobe rises or
  // after the previous ready while the strobe stays up.
  initial begin
    bit prev_strobe;
    int mcnt;
    prev_strobe    = 1'b0;
    mcnt           = 0;
    mem.mem_ready  = 1'b0;
    mem.mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      mem.mem_ready = 1'b0;
      if (!rst || !(mem.mem_rd || mem.mem_wr)) begin
        mcnt        = 0;
        prev_strobe = 1'b0;
      end else begin
        if (!prev_strobe) mcnt = 0;
        else              mcnt++;
        prev_strobe = 1'b1;
        if (mcnt == mem_lat) begin
          mcnt          = 0;
          mem.mem_ready = 1'b1;
          if (mem.mem_rd) begin
            mem.mem_rdata = mem_arr[mem.mem_addr];
            rd_addrs.push_back(mem.mem_addr);
          end else begin
            mem_arr[mem.mem_addr] = mem.mem_wdata;
            wr_addrs.push_back(mem.mem_addr);
            wr_datas.push_back(mem.mem_wdata);
          end
        end
      end
    end
  end

  task automatic ref_reset();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    ref_hits   = 0;
    ref_misses = 0;
  endtask

  // One core access: drive, wait for ack (bounded), check against the model.
  task automatic do_access(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input int lat_cfg,
                           input string name);
    int                lat;
    int                exp_lat;
    bit                acked;
    bit                exp_hit;
    logic [DATA_W-1:0] got;
    int                idx;
    logic [TAG_W-1:0]  tg;
    logic [ADDR_W-1:0] line_base;
    idx       = int'(addr[OFFSET_W +: INDEX_W]);
    tg        = addr[ADDR_W-1 -: TAG_W];
    line_base = {addr[ADDR_W-1:OFFSET_W], 2'b00};
    exp_hit   = ref_valid[idx] && (ref_tag[idx] == tg);
    mem_lat   = lat_cfg;
    rd_addrs.delete();
    wr_addrs.delete();
    wr_datas.delete();

    cpu.cpu_rd    = rd;
    cpu.cpu_wr    = wr;
    cpu.cpu_addr  = addr;
    cpu.cpu_wdata = wdata;
    lat   = 0;
    acked = 1'b0;
    got   = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!cpu.stall) begin
        acked = 1'b1;
        got   = cpu.cpu_rdata;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    @(posedge clk);
    #1;
    cpu.cpu_rd = 1'b0;
    cpu.cpu_wr = 1'b0;

    if (wr)           exp_lat = 1 + lat_cfg;
    else if (exp_hit) exp_lat = 1;
    else              exp_lat = 3 + 4 * lat_cfg;

    checks++;
    if (!acked) begin
      errors++;
      $display("FAIL %s ack_timeout: no ack within 100 cycles, required latency %0d", name, exp_lat);
      return;
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end

    if (!wr) begin
      checks++;
      if (got !== exp_mem[addr]) begin
        errors++;
        $display("FAIL %s rdata @%h: got %h required %h", name, addr, got, exp_mem[addr]);
      end
    end

    checks++;
    if (rd_addrs.size() !== ((!wr && !exp_hit) ? 4 : 0)) begin
      errors++;
      $display("FAIL %s mem_rd_beats: got %0d required %0d", name, rd_addrs.size(),
               (!wr && !exp_hit) ? 4 : 0);
    end else if (!wr && !exp_hit) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rd_addrs[k] !== line_base + ADDR_W'(k)) begin
          errors++;
          $display("FAIL %s refill_addr[%0d]: got %h required %h", name, k, rd_addrs[k],
                   line_base + ADDR_W'(k));
        end
      end
    end

    checks++;
    if (wr_addrs.size() !== (wr ? 1 : 0)) begin
      errors++;
      $display("FAIL %s mem_wr_beats: got %0d required %0d", name, wr_addrs.size(), wr ? 1 : 0);
    end else if (wr) begin
      checks++;
      if (wr_addrs[0] !== addr || wr_datas[0] !== wdata) begin
        errors++;
        $display("FAIL %s store_beat: got %h<=%h required %h<=%h", name, wr_addrs[0],
                 wr_datas[0], addr, wdata);
      end
    end

    if (wr) begin
      exp_mem[addr] = wdata;
    end else if (exp_hit) begin
      ref_hits++;
    end else begin
      ref_misses++;
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
    end

    checks++;
    if (hit_cnt !== (STATS ? 16'(ref_hits) : 16'd0) ||
        miss_cnt !== (STATS ? 16'(ref_misses) : 16'd0)) begin
      errors++;
      $display("FAIL %s stats: got hit=%0d miss=%0d required hit=%0d miss=%0d", name, hit_cnt,
               miss_cnt, STATS ? ref_hits : 0, STATS ? ref_misses : 0);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    cpu.cpu_rd    = 1'b0;
    cpu.cpu_wr    = 1'b0;
    cpu.cpu_addr  = '0;
    cpu.cpu_wdata = '0;
    ref_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cpu.stall, mem.mem_rd, mem.mem_wr} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got stall/rd/wr=%b required 000",
               {cpu.stall, mem.mem_rd, mem.mem_wr});
    end
    checks++;
    if (mem.mem_addr !== '0 || mem.mem_wdata !== '0 || cpu.cpu_rdata !== '0) begin
      errors++;
      $display("FAIL reset_buses: got addr=%h wdata=%h rdata=%h required zeros", mem.mem_addr,
               mem.mem_wdata, cpu.cpu_rdata);
    end
    checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stats: got hit=%0d miss=%0d required 0 0", hit_cnt, miss_cnt);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cold_read();
    do_access(1'b1, 1'b0, 12'h010, '0, 2, "cold_read_010");
  endtask

  task automatic test_read_hit();
    do_access(1'b1, 1'b0, 12'h012, '0, 2, "read_hit_012");
  endtask

  task automatic test_store_hit();
    do_access(1'b0, 1'b1, 12'h011, 32'hDEADBEEF, 1, "store_hit_011");
    do_access(1'b1, 1'b0, 12'h011, '0, 1, "reread_011");
  endtask

  task automatic test_store_miss();
    do_access(1'b0, 1'b1, 12'h200, 32'h1234_5678, 2, "store_miss_200");
    do_access(1'b1, 1'b0, 12'h200, '0, 1, "read_after_store_200");
  endtask

  task automatic test_rd_wr_both();
    do_access(1'b1, 1'b1, 12'h020, 32'h0BAD_F00D, 1, "rd_wr_both_020");
  endtask

  task automatic test_reset_mid_refill();
    bit seen;
    mem_lat = 2;
    rd_addrs.delete();
    cpu.cpu_rd   = 1'b1;
    cpu.cpu_wr   = 1'b0;
    cpu.cpu_addr = 12'h040;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #2;
      if (rd_addrs.size() >= 1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midrst_first_beat: got 0 beats required 1");
    end
    @(posedge clk);
    #2;
    checks++;
    if (mem.mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL midrst_second_word: got mem_rd=%b required 1", mem.mem_rd);
    end
    rst        = 1'b0;
    cpu.cpu_rd = 1'b0;
    #1;
    checks++;
    if (mem.mem_rd !== 1'b0 || mem.mem_addr !== '0) begin
      errors++;
      $display("FAIL midrst_abort: got mem_rd=%b addr=%h required 0 000", mem.mem_rd,
               mem.mem_addr);
    end
    ref_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_access(1'b1, 1'b0, 12'h040, '0, 1, "read_after_midrst_040");
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    int                op;
    do_access(1'b1, 1'b0, 12'hFFF, '0, 1, "top_of_space_FFF");
    do_access(1'b1, 1'b0, 12'hFFC, '0, 1, "top_line_hit_FFC");
    for (int n = 0; n < 40; n++) begin
      a  = ADDR_W'(($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) |
                   $urandom_range(0, 3));
      op = int'($urandom_range(0, 3));
      do_access(op != 2, op >= 2, a, $urandom, int'($urandom_range(1, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_read_hit();
    test_store_hit();
    test_store_miss();
    test_rd_wr_both();
    test_reset_mid_refill();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
